// File: rtl/opb_simulink2opb_master.sv
// Single-outstanding OPB word master: valid/ready request in, one-cycle response out (3 cycles best case).
// No response backpressure. `OPB_MASTER_WATCHDOG_EN adds a local transfer watchdog.
module opb_simulink2opb_master #(
  parameter int C_OPB_AWIDTH  = 32,
  parameter int C_OPB_DWIDTH  = 32,
  parameter int C_MAX_RETRY   = 4,
  parameter int C_WDOG_CYCLES = 255
) (
  input  logic                      OPB_Clk,
  input  logic                      OPB_Rst_n,
  output logic                      M_request,
  output logic                      M_select,
  output logic [0:C_OPB_AWIDTH-1]   M_ABus,
  output logic [0:C_OPB_DWIDTH/8-1] M_BE,
  output logic [0:C_OPB_DWIDTH-1]   M_DBus,
  output logic                      M_RNW,
  output logic                      M_seqAddr,
  output logic                      M_busLock,
  input  logic                      OPB_MGrant,
  input  logic [0:C_OPB_DWIDTH-1]   OPB_DBus,
  input  logic                      OPB_xferAck,
  input  logic                      OPB_errAck,
  input  logic                      OPB_retry,
  input  logic                      OPB_timeout,
  input  logic                      req_valid,
  output logic                      req_ready,
  input  logic                      req_rnw,
  input  logic [C_OPB_AWIDTH-1:0]   req_addr,
  input  logic [C_OPB_DWIDTH-1:0]   req_wdata,
  output logic                      rsp_valid,
  output logic [C_OPB_DWIDTH-1:0]   rsp_rdata,
  output logic [1:0]                rsp_status
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_XFER, S_DONE} state_t;

  localparam logic [3:0] LP_MAX_RETRY = 4'(C_MAX_RETRY);

  state_t                    r_state;
  state_t                    w_next;
  logic                      r_rnw;
  logic [C_OPB_AWIDTH-1:0]   r_addr;
  logic [C_OPB_DWIDTH-1:0]   r_wdata;
  logic [C_OPB_DWIDTH-1:0]   r_rdata;
  logic [1:0]                r_status;
  logic [3:0]                r_retry;
  logic                      w_accept;
  logic                      w_finish;
  logic                      w_retry_again;
  logic [1:0]                w_status;
  logic [C_OPB_DWIDTH-1:0]   w_rdata;
  logic                      w_wdog_hit;
  logic                      w_sel;

`ifdef OPB_MASTER_WATCHDOG_EN
  logic [15:0] r_wdog;

  // Held at zero outside XFER, so every entry into XFER (including after a retry) restarts it.
  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n)             r_wdog <= '0;
    else if (r_state != S_XFER) r_wdog <= '0;
    else                        r_wdog <= r_wdog + 16'd1;
  end

  assign w_wdog_hit = (r_state == S_XFER) && (r_wdog == 16'(C_WDOG_CYCLES - 1));
`else
  assign w_wdog_hit = 1'b0;
`endif

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next        = r_state;
    w_accept      = 1'b0;
    w_finish      = 1'b0;
    w_retry_again = 1'b0;
    w_status      = 2'b00;
    w_rdata       = '0;
    case (r_state)
      S_IDLE: begin
        if (req_valid) begin
          w_accept = 1'b1;
          w_next   = S_REQ;
        end
      end
      S_REQ: begin
        if (OPB_MGrant) w_next = S_XFER;
      end
      S_XFER: begin
        // Termination priority: errAck > xferAck > retry > timeout/watchdog.
        if (OPB_errAck) begin
          w_finish = 1'b1;
          w_status = 2'b01;
        end else if (OPB_xferAck) begin
          w_finish = 1'b1;
          w_status = 2'b00;
          if (r_rnw) w_rdata = OPB_DBus;
        end else if (OPB_retry) begin
          if (r_retry < LP_MAX_RETRY) begin
            w_retry_again = 1'b1;
          end else begin
            w_finish = 1'b1;
            w_status = 2'b11;
          end
        end else if (OPB_timeout || w_wdog_hit) begin
          w_finish = 1'b1;
          w_status = 2'b10;
        end
        if (w_finish)           w_next = S_DONE;
        else if (w_retry_again) w_next = S_REQ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge OPB_Clk or negedge OPB_Rst_n) begin
    if (!OPB_Rst_n) begin
      r_rnw    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_status <= 2'b00;
      r_retry  <= 4'd0;
    end else begin
      if (w_accept) begin
        r_rnw   <= req_rnw;
        r_addr  <= {req_addr[C_OPB_AWIDTH-1:2], 2'b00};
        r_wdata <= req_wdata;
        r_retry <= 4'd0;
      end
      if (w_retry_again) r_retry <= r_retry + 4'd1;
      if (w_finish) begin
        r_status <= w_status;
        r_rdata  <= w_rdata;
      end
    end
  end

  // Bus outputs decode straight from the state register so they are gated to zero
  // the moment select drops, including on asynchronous reset.
  assign w_sel      = (r_state == S_XFER);
  assign M_request  = (r_state == S_REQ);
  assign M_select   = w_sel;
  assign M_ABus     = w_sel ? r_addr : '0;
  assign M_BE       = w_sel ? '1 : '0;
  assign M_DBus     = (w_sel && !r_rnw) ? r_wdata : '0;
  assign M_RNW      = w_sel & r_rnw;
  assign M_seqAddr  = 1'b0;
  assign M_busLock  = 1'b0;
  assign req_ready  = (r_state == S_IDLE) & OPB_Rst_n;
  assign rsp_valid  = (r_state == S_DONE);
  assign rsp_rdata  = r_rdata;
  assign rsp_status = r_status;

endmodule
